ram_port_bridge: RTL and testbench
==================================

Name: ram_port_bridge

Overview:
- Upstream adapter between a core-side load/store or fetch request interface (req/gnt/rvalid protocol) and one port of the single-cycle-latency dual-port RAM model.
- Handles address decode and range check, and converts byte addresses to word indices.
- Inserts pseudo-random, bounded grant stalls for verification.
- Generates the one-cycle-later response, and keeps read/write access counters.
- One instance per RAM port (instruction side, data side).

Parameters:
- ADDR_WIDTH, 8, RAM word-index width; the window covers 4*2^ADDR_WIDTH bytes.
- BASE_ADDR, 32'h0000_0000, byte base of the RAM window; must be 4-byte aligned.
- LFSR_SEED, 16'hACE1, stall LFSR reset value; 0 is replaced by 16'h0001.
- MAX_STALL, 3, maximum consecutive stall cycles before a grant is forced (1..15).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- stall_en_i  in  1  enables random grant stalls.
- req_i  in  1  core request.
- gnt_o  out  1  grant, combinational.
- addr_i  in  32  byte address.
- we_i  in  1  write enable.
- be_i  in  4  byte enables.
- wdata_i  in  32  write data.
- rvalid_o  out  1  response valid.
- rdata_o  out  32  read data.
- err_o  out  1  response error (out of range).
- ram_en_o  out  1  RAM port enable.
- ram_addr_o  out  ADDR_WIDTH  RAM word index.
- ram_we_o  out  1  RAM write enable.
- ram_be_o  out  4  RAM byte enables.
- ram_wdata_o  out  32  RAM write data.
- ram_rdata_i  in  32  RAM read data; registered by the RAM, valid the cycle after ram_en_o.
- rd_cnt_o  out  32  completed in-range reads.
- wr_cnt_o  out  32  completed in-range writes.

Behaviour:
- Reset (rst=1 at a clock edge):
  - rvalid_o=0, err_o=0, rdata_o=0.
  - Counters=0, stall counter=0, LFSR=LFSR_SEED (or 16'h0001 if LFSR_SEED is 0).
  - Internal response registers cleared.
  - While rst=1: gnt_o=0 and ram_en_o=0.
- LFSR:
  - 16-bit Fibonacci; fb = l[15]^l[13]^l[12]^l[10]; next = {l[14:0], fb}.
  - Advances every non-reset cycle, regardless of req_i.
- Stall decision:
  - stall = stall_en_i & req_i & (lfsr[1:0]==2'b00) & (stall_cnt < MAX_STALL).
  - stall_cnt increments on a stalled cycle and clears on any grant or when req_i=0.
  - Any request is therefore granted within MAX_STALL+1 cycles.
- Grant:
  - gnt_o = req_i & ~stall & ~rst.
  - No state is needed besides the response pipeline; back-to-back grants on consecutive cycles are allowed.
- Decode:
  - off = addr_i - BASE_ADDR (32-bit, wrapping).
  - in_range = (off >> (ADDR_WIDTH+2)) == 0.
  - ram_addr_o = off[ADDR_WIDTH+1:2]; addr_i[1:0] is ignored; be_i selects bytes.
- RAM drive (combinational in the grant cycle):
  - ram_en_o = gnt_o & in_range; ram_we_o = we_i & ram_en_o.
  - ram_be_o = be_i; ram_wdata_o = wdata_i.
  - Out-of-range grants never assert ram_en_o.
- Response, fixed latency 1:
  - A grant in cycle N gives rvalid_o=1 in cycle N+1, exactly one cycle per grant.
  - err_o = ~in_range captured at grant.
  - rdata_o = ram_rdata_i for an in-range read, otherwise 32'h0.
  - rdata_o is held until the next response; it is only meaningful when rvalid_o=1.
  - rvalid_o=0 in any cycle not preceded by a grant.
- Counters:
  - rd_cnt_o / wr_cnt_o increment in the response cycle of an in-range read/write.
  - Errored accesses are not counted.
  - Counters wrap at 2^32.
- Reset mid-operation: rst asserted in the cycle after a grant drops that response (rvalid_o=0); the RAM write, if any, has already been issued.
- Unchanged inputs while req_i=1 and gnt_o=0 are the core's responsibility; the bridge does not check them.

Test Plan:
1. Write then read (ADDR_WIDTH=8, BASE=0, stall_en_i=0): write 0x12345678 to 0x10 with be=4'hF, then read 0x10.
   -> gnt_o=1 in the same cycle as each request; ram_addr_o=0x04; rvalid_o one cycle later; read rdata_o=0x12345678, err_o=0; wr_cnt_o=1, rd_cnt_o=1.
2. Byte enables: write 0xAABBCCDD to 0x20 with be=4'b0101 over 0 contents, then read 0x20.
   -> rdata_o=0x00BB00DD.
3. Back-to-back: reads on 4 consecutive cycles to 0x0, 0x4, 0x8, 0xC.
   -> 4 consecutive grants; rvalid_o high for 4 consecutive cycles, each one cycle after its grant; data returned in order.
4. Out of range: read 0x400, then write 0xFFFF_FFFC.
   -> granted; ram_en_o=0; rvalid_o with err_o=1, rdata_o=0; counters unchanged.
5. Stall bound: stall_en_i=1, req_i held for 1000 requests.
   -> no request waits more than MAX_STALL (3) cycles before gnt_o; at least one stall observed; with LFSR_SEED=0 the sequence matches seed 0x0001.
6. Reset mid-op: grant a read, assert rst the next cycle.
   -> rvalid_o=0; all outputs reset; the first post-reset request behaves as in scenario 1.

Source files
------------

// File: rtl/ram_port_bridge_if.sv
// Core-side req/gnt/rvalid bus between a load/store or fetch unit and the RAM port bridge.
// master = core (issues requests), slave = bridge (grants and responds).
interface ram_port_bridge_if;
  logic        req_i;
  logic        gnt_o;
  logic [31:0] addr_i;
  logic        we_i;
  logic [3:0]  be_i;
  logic [31:0] wdata_i;
  logic        rvalid_o;
  logic [31:0] rdata_o;
  logic        err_o;

  modport master (
    output req_i, addr_i, we_i, be_i, wdata_i,
    input  gnt_o, rvalid_o, rdata_o, err_o
  );

  modport slave (
    input  req_i, addr_i, we_i, be_i, wdata_i,
    output gnt_o, rvalid_o, rdata_o, err_o
  );
endinterface

// File: rtl/ram_port_bridge.sv
// Bridges a core req/gnt/rvalid port onto one port of a 1-cycle-latency RAM: decode, range check,
// LFSR-driven bounded grant stalls, fixed 1-cycle response and in-range read/write counters.
module ram_port_bridge #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1,
  parameter int unsigned MAX_STALL  = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    stall_en_i,
  ram_port_bridge_if.slave        core,
  output logic                    ram_en_o,
  output logic [ADDR_WIDTH-1:0]   ram_addr_o,
  output logic                    ram_we_o,
  output logic [3:0]              ram_be_o,
  output logic [31:0]             ram_wdata_o,
  input  logic [31:0]             ram_rdata_i,
  output logic [31:0]             rd_cnt_o,
  output logic [31:0]             wr_cnt_o
);

  // An all-zero Fibonacci LFSR would lock up, so a zero seed is promoted.
  localparam logic [15:0] SEED = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;

  logic [15:0] lfsr;
  logic [3:0]  stall_cnt;
  logic        stall;
  logic [31:0] off;
  logic        in_range;
  logic        rsp_vld;
  logic        rsp_err;
  logic        rsp_we;
  logic [31:0] rdata_q;
  logic [31:0] rdata_sel;

  assign off      = core.addr_i - BASE_ADDR;
  assign in_range = (off >> (ADDR_WIDTH + 2)) == 32'd0;

  assign stall = stall_en_i & core.req_i & (lfsr[1:0] == 2'b00)
               & (stall_cnt < 4'(MAX_STALL));

  assign core.gnt_o  = core.req_i & ~stall & ~rst;
  assign ram_en_o    = core.gnt_o & in_range;
  assign ram_we_o    = core.we_i & ram_en_o;
  assign ram_addr_o  = off[ADDR_WIDTH+1:2];
  assign ram_be_o    = core.be_i;
  assign ram_wdata_o = core.wdata_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr      <= SEED;
      stall_cnt <= 4'd0;
    end else begin
      lfsr      <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      stall_cnt <= stall ? stall_cnt + 4'd1 : 4'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_vld <= 1'b0;
      rsp_err <= 1'b0;
      rsp_we  <= 1'b0;
    end else begin
      rsp_vld <= core.gnt_o;
      rsp_err <= ~in_range;
      rsp_we  <= core.we_i;
    end
  end

  // RAM data arrives combinationally in the response cycle; the register only holds it afterwards.
  assign rdata_sel     = (rsp_err | rsp_we) ? 32'h0 : ram_rdata_i;
  assign core.rvalid_o = rsp_vld & ~rst;
  assign core.err_o    = core.rvalid_o & rsp_err;
  assign core.rdata_o  = rst ? 32'h0 : (rsp_vld ? rdata_sel : rdata_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q  <= 32'h0;
      rd_cnt_o <= 32'd0;
      wr_cnt_o <= 32'd0;
    end else if (rsp_vld) begin
      rdata_q <= rdata_sel;
      if (!rsp_err && !rsp_we) rd_cnt_o <= rd_cnt_o + 32'd1;
      if (!rsp_err &&  rsp_we) wr_cnt_o <= wr_cnt_o + 32'd1;
    end
  end

endmodule

// File: tb/tb_ram_port_bridge.sv
// Directed bench for ram_port_bridge with a behavioural 1-cycle RAM and a grant-stall reference.
module tb_ram_port_bridge;
  logic        clk = 1'b0;
  logic        rst;
  logic        stall_en;
  logic        ram_en, ram_we;
  logic [7:0]  ram_addr;
  logic [3:0]  ram_be;
  logic [31:0] ram_wdata, ram_rdata, rd_cnt, wr_cnt;
  logic [31:0] mem [256];

  int n_cmp = 0;
  int n_mis = 0;

  ram_port_bridge_if bus ();

  ram_port_bridge #(
    .ADDR_WIDTH (8),
    .BASE_ADDR  (32'h0000_0000),
    .LFSR_SEED  (16'h0000),
    .MAX_STALL  (3)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .stall_en_i  (stall_en),
    .core        (bus.slave),
    .ram_en_o    (ram_en),
    .ram_addr_o  (ram_addr),
    .ram_we_o    (ram_we),
    .ram_be_o    (ram_be),
    .ram_wdata_o (ram_wdata),
    .ram_rdata_i (ram_rdata),
    .rd_cnt_o    (rd_cnt),
    .wr_cnt_o    (wr_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we)
        for (int b = 0; b < 4; b++)
          if (ram_be[b]) mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
      ram_rdata <= mem[ram_addr];
    end
  end

  // Reference stall generator seeded with 16'h0001, the value a zero seed must map to.
  logic [15:0] m_lfsr;
  logic [3:0]  m_sc;
  logic        m_stall, m_gnt;
  assign m_stall = stall_en & bus.req_i & (m_lfsr[1:0] == 2'b00) & (m_sc < 4'd3);
  assign m_gnt   = bus.req_i & ~m_stall & ~rst;
  always @(posedge clk) begin
    if (rst) begin
      m_lfsr <= 16'h0001;
      m_sc   <= 4'd0;
    end else begin
      m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
      m_sc   <= m_stall ? m_sc + 4'd1 : 4'd0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic issue(input logic [31:0] a, input logic w, input logic [3:0] b, input logic [31:0] d);
    bus.req_i   = 1'b1;
    bus.addr_i  = a;
    bus.we_i    = w;
    bus.be_i    = b;
    bus.wdata_i = d;
  endtask

  task automatic idle();
    bus.req_i = 1'b0;
    bus.we_i  = 1'b0;
  endtask

  initial begin
    int grants, waits, max_wait, stalls, seq_mis, cycles;
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    ram_rdata = 32'h0;
    stall_en  = 1'b0;
    rst       = 1'b1;
    issue(32'h10, 1'b0, 4'hF, 32'h0);

    // Reset: request held high must still see no grant.
    repeat (2) @(negedge clk);
    #1;
    chk("rst_gnt", bus.gnt_o, 0);
    chk("rst_ram_en", ram_en, 0);
    chk("rst_rvalid", bus.rvalid_o, 0);
    chk("rst_rdata", bus.rdata_o, 0);
    chk("rst_err", bus.err_o, 0);
    chk("rst_rd_cnt", rd_cnt, 0);
    chk("rst_wr_cnt", wr_cnt, 0);
    idle();
    @(negedge clk);
    rst = 1'b0;

    // 1: write then read 0x10
    @(negedge clk); issue(32'h10, 1'b1, 4'hF, 32'h1234_5678); #1;
    chk("s1_wr_gnt", bus.gnt_o, 1);
    chk("s1_wr_ram_addr", ram_addr, 32'h4);
    chk("s1_wr_ram_we", ram_we, 1);
    @(negedge clk); idle(); #1;
    chk("s1_wr_rvalid", bus.rvalid_o, 1);
    chk("s1_wr_err", bus.err_o, 0);
    @(negedge clk); issue(32'h10, 1'b0, 4'hF, 32'h0); #1;
    chk("s1_idle_rvalid", bus.rvalid_o, 0);
    chk("s1_wr_cnt", wr_cnt, 1);
    chk("s1_rd_gnt", bus.gnt_o, 1);
    chk("s1_rd_ram_addr", ram_addr, 32'h4);
    @(negedge clk); idle(); #1;
    chk("s1_rd_rvalid", bus.rvalid_o, 1);
    chk("s1_rd_rdata", bus.rdata_o, 32'h1234_5678);
    chk("s1_rd_err", bus.err_o, 0);
    @(negedge clk); #1;
    chk("s1_rd_cnt", rd_cnt, 1);
    chk("s1_rdata_hold", bus.rdata_o, 32'h1234_5678);

    // 2: partial byte-enable write
    @(negedge clk); issue(32'h20, 1'b1, 4'b0101, 32'hAABB_CCDD);
    @(negedge clk); issue(32'h20, 1'b0, 4'hF, 32'h0);
    @(negedge clk); idle(); #1;
    chk("s2_rdata_be", bus.rdata_o, 32'h00BB_00DD);

    // 3: back-to-back writes then reads to 0x0..0xC
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); issue(32'(4*i), 1'b1, 4'hF, 32'hC0DE_0000 + 32'(i));
    end
    @(negedge clk); idle();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); issue(32'(4*i), 1'b0, 4'hF, 32'h0); #1;
      chk($sformatf("s3_gnt%0d", i), bus.gnt_o, 1);
      if (i > 0) begin
        chk($sformatf("s3_rvalid%0d", i-1), bus.rvalid_o, 1);
        chk($sformatf("s3_rdata%0d", i-1), bus.rdata_o, 32'hC0DE_0000 + 32'(i-1));
      end
    end
    @(negedge clk); idle(); #1;
    chk("s3_rvalid3", bus.rvalid_o, 1);
    chk("s3_rdata3", bus.rdata_o, 32'hC0DE_0003);
    @(negedge clk); #1;
    chk("s3_rvalid_end", bus.rvalid_o, 0);
    chk("s3_rd_cnt", rd_cnt, 6);
    chk("s3_wr_cnt", wr_cnt, 6);

    // 4: out of range read and write
    @(negedge clk); issue(32'h400, 1'b0, 4'hF, 32'h0); #1;
    chk("s4_rd_gnt", bus.gnt_o, 1);
    chk("s4_rd_ram_en", ram_en, 0);
    @(negedge clk); issue(32'hFFFF_FFFC, 1'b1, 4'hF, 32'hDEAD_BEEF); #1;
    chk("s4_rd_rvalid", bus.rvalid_o, 1);
    chk("s4_rd_err", bus.err_o, 1);
    chk("s4_rd_rdata", bus.rdata_o, 0);
    chk("s4_wr_gnt", bus.gnt_o, 1);
    chk("s4_wr_ram_en", ram_en, 0);
    @(negedge clk); idle(); #1;
    chk("s4_wr_rvalid", bus.rvalid_o, 1);
    chk("s4_wr_err", bus.err_o, 1);
    @(negedge clk); #1;
    chk("s4_rd_cnt", rd_cnt, 6);
    chk("s4_wr_cnt", wr_cnt, 6);

    // 5: random stalls, 1000 requests held back-to-back
    stall_en = 1'b1;
    grants = 0; waits = 0; max_wait = 0; stalls = 0; seq_mis = 0; cycles = 0;
    while (grants < 1000 && cycles < 5000) begin
      @(negedge clk); issue(32'h0, 1'b0, 4'hF, 32'h0); #1;
      cycles++;
      if (bus.gnt_o !== m_gnt) seq_mis++;
      if (bus.gnt_o === 1'b1) begin
        if (waits > max_wait) max_wait = waits;
        waits = 0;
        grants++;
      end else begin
        waits++;
        stalls++;
      end
    end
    chk("s5_grant_count", 32'(grants), 1000);
    chk("s5_wait_over_3", 32'(max_wait > 3), 0);
    chk("s5_stall_seen", 32'(stalls > 0), 1);
    chk("s5_seed1_seq", 32'(seq_mis), 0);
    @(negedge clk); idle(); stall_en = 1'b0;
    @(negedge clk); #1;
    chk("s5_rd_cnt", rd_cnt, 1006);

    // 6: reset in the cycle after a grant
    @(negedge clk); issue(32'h10, 1'b0, 4'hF, 32'h0); #1;
    chk("s6_gnt", bus.gnt_o, 1);
    @(negedge clk); idle(); rst = 1'b1; #1;
    chk("s6_rvalid_dropped", bus.rvalid_o, 0);
    @(negedge clk); rst = 1'b0; #1;
    chk("s6_rd_cnt", rd_cnt, 0);
    chk("s6_wr_cnt", wr_cnt, 0);
    chk("s6_rvalid", bus.rvalid_o, 0);
    chk("s6_rdata", bus.rdata_o, 0);
    @(negedge clk); issue(32'h10, 1'b0, 4'hF, 32'h0); #1;
    chk("s6_post_gnt", bus.gnt_o, 1);
    @(negedge clk); idle(); #1;
    chk("s6_post_rvalid", bus.rvalid_o, 1);
    chk("s6_post_rdata", bus.rdata_o, 32'h1234_5678);
    @(negedge clk); #1;
    chk("s6_post_rd_cnt", rd_cnt, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
